// File: rtl/control_unit_if.sv
// Control bundle between control_unit (master) and data_path (slave).
// Carries instruction/status inputs to the sequencer and every strobe back out.
interface control_unit_if;
   logic       stop;
   logic [31:0] irOut;
   logic       branchCompare;
   logic       run;
   logic       Gra, Grb, Grc, Rin, Rout, BAOut, CONin;
   logic       HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Cout;
   logic       HIin, LOin, Zhighin, Zlowin, PCin, MDRin, OutPortin, Yin, MARin, IncPC, irIn;
   logic       Read, Write;
   logic [4:0] op_in;

   modport master (
      input  stop, irOut, branchCompare,
      output run, Gra, Grb, Grc, Rin, Rout, BAOut, CONin,
             HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Cout,
             HIin, LOin, Zhighin, Zlowin, PCin, MDRin, OutPortin, Yin, MARin, IncPC, irIn,
             Read, Write, op_in
   );

   modport slave (
      output stop, irOut, branchCompare,
      input  run, Gra, Grb, Grc, Rin, Rout, BAOut, CONin,
             HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Cout,
             HIin, LOin, Zhighin, Zlowin, PCin, MDRin, OutPortin, Yin, MARin, IncPC, irIn,
             Read, Write, op_in
   );
endinterface

// File: rtl/control_unit.sv
// Hardwired Moore sequencer: fetch in T0-T2, opcode-specific execute in T3-T7.
// Outputs depend only on the state register and irOut; stop is honoured at the T0 boundary.
module control_unit #(
   parameter logic [4:0] OP_ADD = 5'b00011
) (
   input  logic             clock,
   input  logic             clear,
   control_unit_if.master   bus
);

   localparam logic [3:0] RST  = 4'd0;
   localparam logic [3:0] T0   = 4'd1;
   localparam logic [3:0] T1   = 4'd2;
   localparam logic [3:0] T2   = 4'd3;
   localparam logic [3:0] T3   = 4'd4;
   localparam logic [3:0] T4   = 4'd5;
   localparam logic [3:0] T5   = 4'd6;
   localparam logic [3:0] T6   = 4'd7;
   localparam logic [3:0] T7   = 4'd8;
   localparam logic [3:0] HALT = 4'd9;

   logic [3:0] state, nxt;
   logic [4:0] opc;
   logic       is_alu, is_imm, is_muldiv, is_negnot, is_ld, is_ldi, is_st, is_brx;
   logic       is_jr, is_jal, is_in, is_out, is_mfhi, is_mflo, is_nop, is_halt, is_mem;
   logic       unused_bits;

   assign opc         = bus.irOut[31:27];
   assign unused_bits = ^{bus.irOut[26:0], bus.branchCompare};

   assign is_alu    = (opc >= 5'd3)  && (opc <= 5'd11);
   assign is_imm    = (opc >= 5'd12) && (opc <= 5'd14);
   assign is_muldiv = (opc == 5'd15) || (opc == 5'd16);
   assign is_negnot = (opc == 5'd17) || (opc == 5'd18);
   assign is_ld     = (opc == 5'd0);
   assign is_ldi    = (opc == 5'd1);
   assign is_st     = (opc == 5'd2);
   assign is_brx    = (opc == 5'd19);
   assign is_jr     = (opc == 5'd20);
   assign is_jal    = (opc == 5'd21);
   assign is_in     = (opc == 5'd22);
   assign is_out    = (opc == 5'd23);
   assign is_mfhi   = (opc == 5'd24);
   assign is_mflo   = (opc == 5'd25);
   assign is_halt   = (opc == 5'd27);
   assign is_nop    = (opc == 5'd26) || (opc >= 5'd28);
   assign is_mem    = is_ld || is_ldi || is_st;

   always_ff @(posedge clock) begin
      if (!clear) state <= RST;
      else        state <= nxt;
   end

   always_comb begin
      nxt = RST;
      case (state)
         RST:  nxt = T0;
         T0:   nxt = bus.stop ? HALT : T1;
         T1:   nxt = T2;
         T2:   nxt = is_halt ? HALT : (is_nop ? T0 : T3);
         T3:   nxt = (is_jr || is_in || is_out || is_mfhi || is_mflo) ? T0 : T4;
         T4:   nxt = (is_negnot || is_jal) ? T0 : T5;
         T5:   nxt = (is_alu || is_imm || is_ldi) ? T0 : T6;
         T6:   nxt = (is_muldiv || is_st || is_brx) ? T0 : T7;
         T7:   nxt = T0;
         HALT: nxt = HALT;
         default: nxt = RST;
      endcase
   end

   always_comb begin
      bus.run = (state != RST) && (state != HALT);
      bus.Gra = 1'b0; bus.Grb = 1'b0; bus.Grc = 1'b0; bus.Rin = 1'b0; bus.Rout = 1'b0;
      bus.BAOut = 1'b0; bus.CONin = 1'b0;
      bus.HIout = 1'b0; bus.LOout = 1'b0; bus.Zhighout = 1'b0; bus.Zlowout = 1'b0;
      bus.PCout = 1'b0; bus.MDRout = 1'b0; bus.InPortout = 1'b0; bus.Cout = 1'b0;
      bus.HIin = 1'b0; bus.LOin = 1'b0; bus.Zhighin = 1'b0; bus.Zlowin = 1'b0;
      bus.PCin = 1'b0; bus.MDRin = 1'b0; bus.OutPortin = 1'b0; bus.Yin = 1'b0;
      bus.MARin = 1'b0; bus.IncPC = 1'b0; bus.irIn = 1'b0;
      bus.Read = 1'b0; bus.Write = 1'b0;
      bus.op_in = OP_ADD;
      case (state)
         T0: begin bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zlowin = 1'b1; end
         T1: begin bus.Zlowout = 1'b1; bus.PCin = 1'b1; bus.Read = 1'b1; bus.MDRin = 1'b1; end
         T2: begin bus.MDRout = 1'b1; bus.irIn = 1'b1; end
         T3: begin
            if (is_alu || is_imm) begin bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1; end
            if (is_muldiv) begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1; end
            if (is_negnot) begin
               bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Zlowin = 1'b1; bus.op_in = opc;
            end
            if (is_mem) begin bus.Grb = 1'b1; bus.BAOut = 1'b1; bus.Yin = 1'b1; end
            if (is_brx) begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.CONin = 1'b1; end
            if (is_jr)  begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.PCin = 1'b1; end
            // jal: PC is looped onto the bus so data_path can capture it into R15
            if (is_jal) begin bus.PCout = 1'b1; bus.PCin = 1'b1; end
            if (is_in)  begin bus.InPortout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
            if (is_out) begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.OutPortin = 1'b1; end
            if (is_mfhi) begin bus.HIout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
            if (is_mflo) begin bus.LOout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
         end
         T4: begin
            if (is_alu) begin
               bus.Grc = 1'b1; bus.Rout = 1'b1; bus.Zlowin = 1'b1; bus.op_in = opc;
            end
            if (is_imm) begin bus.Cout = 1'b1; bus.Zlowin = 1'b1; bus.op_in = opc; end
            if (is_muldiv) begin
               bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Zlowin = 1'b1; bus.Zhighin = 1'b1;
               bus.op_in = opc;
            end
            if (is_negnot) begin bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
            if (is_mem) begin bus.Cout = 1'b1; bus.Zlowin = 1'b1; end
            if (is_brx) begin bus.PCout = 1'b1; bus.Yin = 1'b1; end
            if (is_jal) begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.PCin = 1'b1; end
         end
         T5: begin
            if (is_alu || is_imm || is_ldi) begin
               bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
            end
            if (is_muldiv) begin bus.Zlowout = 1'b1; bus.LOin = 1'b1; end
            if (is_ld || is_st) begin bus.Zlowout = 1'b1; bus.MARin = 1'b1; end
            if (is_brx) begin bus.Cout = 1'b1; bus.Zlowin = 1'b1; end
         end
         T6: begin
            if (is_muldiv) begin bus.Zhighout = 1'b1; bus.HIin = 1'b1; end
            if (is_ld) begin bus.Read = 1'b1; bus.MDRin = 1'b1; end
            if (is_st) begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.Write = 1'b1; end
            // branch target is offered unconditionally; data_path gates PC load with CON
            if (is_brx) bus.Zlowout = 1'b1;
         end
         T7: begin
            if (is_ld) begin bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
         end
         default: ;
      endcase
   end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
Hardwired multi-cycle control sequencer that sits directly upstream of data_path and drives every one of its control, enable, Gr* and memory strobes. It is a Moore FSM with a fetch phase (T0-T2) followed by an opcode-specific execute phase (T3-T7). It decodes the opcode from irOut[31:27] and senses branchCompare (CON). It returns to T0 after each instruction, or parks in HALT.

Parameters:
OP_ADD, 5'b00011, ALU opcode driven on op_in for address and PC-relative computations.

Ports:
clock  in  1  system clock; all state changes on rising edge.
clear  in  1  synchronous, active-low reset.
stop  in  1  request halt at the next instruction boundary.
irOut  in  32  instruction register contents; opcode is irOut[31:27].
branchCompare  in  1  CON flip-flop output (informational; PC gating is done inside data_path).
run  out  1  1 while sequencing; 0 in RST and HALT.
Gra, Grb, Grc, Rin, Rout, BAOut, CONin  out  1 each  register-select and CON controls.
HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Cout  out  1 each  bus source selects.
HIin, LOin, Zhighin, Zlowin, PCin, MDRin, OutPortin, Yin, MARin, IncPC, irIn  out  1 each  register enables.
Read, Write  out  1 each  memory strobes.
op_in  out  5  ALU operation.

Behaviour:
- States: RST, T0..T7, HALT. Outputs are a pure function of the state register and irOut (Moore); no combinational path from clear or stop to any output.
- Reset: clear==0 at a rising edge sets the state to RST, including mid-instruction. In RST, every output is 0 and op_in is OP_ADD. RST always goes to T0 on the next edge with clear==1.
- Default values in every state: all strobes 0, op_in = OP_ADD. Listed signals are 1 for that state only.
- T0: PCout, MARin, IncPC, Zlowin. If stop==1 at the edge leaving T0, go to HALT instead of T1.
- T1: Zlowout, PCin, Read, MDRin.
- T2: MDRout, irIn.
- Execute sequences by opcode. The last step listed returns to T0.
  - add/sub/and/or/shr/shra/shl/ror/rol (00011-01011):
    - T3: Grb, Rout, Yin.
    - T4: Grc, Rout, Zlowin, op_in=opcode.
    - T5: Zlowout, Gra, Rin.
  - addi/andi/ori (01100-01110):
    - T3: Grb, Rout, Yin.
    - T4: Cout, Zlowin, op_in=opcode.
    - T5: Zlowout, Gra, Rin.
  - mul/div (01111, 10000):
    - T3: Gra, Rout, Yin.
    - T4: Grb, Rout, Zlowin, Zhighin, op_in=opcode.
    - T5: Zlowout, LOin.
    - T6: Zhighout, HIin.
  - neg/not (10001, 10010):
    - T3: Grb, Rout, Zlowin, op_in=opcode.
    - T4: Zlowout, Gra, Rin.
  - ld (00000):
    - T3: Grb, BAOut, Yin.
    - T4: Cout, Zlowin.
    - T5: Zlowout, MARin.
    - T6: Read, MDRin.
    - T7: MDRout, Gra, Rin.
  - ldi (00001):
    - T3: Grb, BAOut, Yin.
    - T4: Cout, Zlowin.
    - T5: Zlowout, Gra, Rin.
  - st (00010):
    - T3: Grb, BAOut, Yin.
    - T4: Cout, Zlowin.
    - T5: Zlowout, MARin.
    - T6: Gra, Rout, Write.
  - brx (10011):
    - T3: Gra, Rout, CONin.
    - T4: PCout, Yin.
    - T5: Cout, Zlowin.
    - T6: Zlowout only; PCin stays 0, and data_path loads PC only when CON==1.
  - jr (10100):
    - T3: Gra, Rout, PCin.
  - jal (10101):
    - T3: PCout, PCin; data_path forces R15in, so R15 gets the return PC.
    - T4: Gra, Rout, PCin.
  - in (10110): T3: InPortout, Gra, Rin.
  - out (10111): T3: Gra, Rout, OutPortin.
  - mfhi (11000): T3: HIout, Gra, Rin.
  - mflo (11001): T3: LOout, Gra, Rin.
  - nop (11010) and undefined opcodes 11100-11111: T2 goes directly to T0.
  - halt (11011): T2 goes to HALT.
- HALT: all outputs 0, run=0. The only exit is reset.
- Instruction length in cycles, including fetch: nop 3; jr/in/out/mfhi/mflo 4; neg/not/jal 5; ALU/imm/ldi 6; mul/div/st/brx 7; ld 8.
- Exactly one bus-source select is 1 in any state, or none.
- Rin and Rout are never 1 in the same state.

Test Plan:
- Hold clear=0 for 2 edges mid-ld (state T5), then release -> all outputs 0 and run=0 during RST; state T0 one edge after release, with PCout=MARin=IncPC=Zlowin=1.
- irOut=32'h18000000 (add) after fetch -> T3 Grb/Rout/Yin, T4 Grc/Rout/Zlowin with op_in=00011, T5 Zlowout/Gra/Rin; T0 reached 6 cycles after the first T0.
- irOut opcode 00000 (ld) -> Read=1 in exactly T1 and T6, Write=0 throughout; 8-cycle instruction.
- irOut opcode 10011 (brx), branchCompare=1 vs 0 -> identical strobe sequence (CONin in T3, Zlowout in T6), PCin=0 in T6 in both cases; 7 cycles.
- irOut opcode 10101 (jal) -> T3 PCout=PCin=1 with Rout=0, T4 Gra=Rout=PCin=1.
- stop=1 sampled in T0 -> HALT next edge, run=0, all strobes 0 for 10+ cycles. Separately, opcode 11011 reaches HALT from T2.
